wb_pipe_stage: RTL

Parametrised MEM/WB pipeline stage register, the successor of the plain write-back latch. Adds a valid bit, ready/valid backpressure, synchronous flush, an optional 2-entry skid buffer for timing-clean stalls, and a saturating stall-cycle counter. It sits between the data-memory stage and register-file write-back. Its gated reg-write output means that bubbles never write the register file.

---
 rtl/wb_pipe_stage_pkg.sv | 21 ++
 rtl/wb_pipe_stage_skid_buf.sv | 70 +++++++
 rtl/wb_pipe_stage.sv | 69 ++++++
 3 files changed

// File: rtl/wb_pipe_stage_pkg.sv
// Shared types for the MEM/WB stage: write-back bundle, register address and skid FSM states.
package wb_pipe_stage_pkg;
    localparam int WORD_W = 32;
    localparam int DATA_W = WORD_W;

    typedef logic [4:0] RegAddr;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] mem_out;
        logic [DATA_W-1:0] alu_out;
        RegAddr            rd_a;
    } wb_bundle_t;

    typedef enum logic [1:0] {SB_EMPTY, SB_ONE, SB_FULL} skid_state_e;

    function automatic logic [DATA_W-1:0] wb_select(input wb_bundle_t b);
        return b.mem_to_reg ? b.mem_out : b.alu_out;
    endfunction
endpackage

// File: rtl/wb_pipe_stage_skid_buf.sv
// Generic 2-entry skid buffer; in_ready depends only on registered state (plus reset).
module skid_buf
    import wb_pipe_stage_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    skid_state_e state, state_d;
    T            head, skid;
    logic        in_fire;
    logic        load_head, load_skid, head_from_skid;

    assign in_ready  = !rst && (state != SB_FULL);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state != SB_EMPTY);
    assign out_data  = head;

    always_comb begin
        state_d        = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            SB_EMPTY: if (in_fire) begin
                state_d   = SB_ONE;
                load_head = 1'b1;
            end
            SB_ONE: begin
                if (in_fire && out_ready) begin
                    load_head = 1'b1;
                end else if (in_fire) begin
                    state_d   = SB_FULL;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_FULL: if (out_ready) begin
                state_d        = SB_ONE;
                head_from_skid = 1'b1;
            end
            default: state_d = SB_EMPTY;
        endcase
    end

    // Flush only drops occupancy; payload registers keep stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SB_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= SB_EMPTY;
        end else begin
            state <= state_d;
            if (load_head)      head <= in_data;
            if (head_from_skid) head <= skid;
            if (load_skid)      skid <= in_data;
        end
    end
endmodule

// File: rtl/wb_pipe_stage.sv
// MEM/WB stage register with valid/ready, flush, optional skid buffer and saturating stall counter.
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  wb_bundle_t        in_bundle,
    output logic              out_valid,
    input  logic              out_ready,
    output wb_bundle_t        out_bundle,
    output logic              reg_write_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [CNT_W-1:0]  stall_cnt
);
    generate
        if (SKID != 0) begin : g_skid
            skid_buf #(.T(wb_bundle_t)) u_skid (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .in_data  (in_bundle),
                .out_valid(out_valid),
                .out_ready(out_ready),
                .out_data (out_bundle)
            );
        end else begin : g_reg
            logic       r_valid;
            wb_bundle_t r_bundle;

            assign in_ready   = !rst && (out_ready || !r_valid);
            assign out_valid  = r_valid;
            assign out_bundle = r_bundle;

            // A new entry takes priority over draining, so fire-in plus fire-out keeps valid high.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid  <= 1'b0;
                    r_bundle <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (in_valid && in_ready) begin
                    r_valid  <= 1'b1;
                    r_bundle <= in_bundle;
                end else if (r_valid && out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign reg_write_o = !rst && out_valid && out_bundle.reg_write;
    assign wb_data_o   = wb_select(out_bundle);

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
